// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder.
//   - Format codes carried on the fmt input (R=0, I=1, S=2, B=3, U=4, J=5; 6-7 are invalid).
//   - Major opcodes of the base integer ISA.
//   - The canonical NOP (addi x0, x0, 0) emitted in place of any erroneous field set.
//   - The field bundle held by the capture stage.
package instr_encoder_pkg;

    typedef enum logic [2:0] {
        FmtR = 3'd0,
        FmtI = 3'd1,
        FmtS = 3'd2,
        FmtB = 3'd3,
        FmtU = 3'd4,
        FmtJ = 3'd5
    } fmt_e;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcJal    = 7'b1101111;

    localparam logic [31:0] NopInstr = {12'd0, 5'd0, 3'd0, 5'd0, OpcOpImm};

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } s1_fields_t;

endpackage

// File: rtl/instr_imm_pack.sv
// Immediate packer and field checker (purely combinational).
// Places the immediate bits of a field set at their instruction-word positions (all other
// bits zero) and flags invalid format codes. When ENC_RANGE_CHECK_EN is defined it also
// flags immediates that do not fit their format; otherwise they are silently truncated.
// Ports:
//   fmt_i        format code
//   imm_i        immediate (signed byte offset or value)
//   imm_field_o  immediate bits in instruction position
//   err_o        field error
module instr_imm_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [31:0] imm_i,
    output logic [31:0] imm_field_o,
    output logic        err_o
);

    always_comb begin
        imm_field_o = '0;
        err_o       = 1'b0;
        case (fmt_i)
            FmtR: imm_field_o = '0;
            FmtI: imm_field_o = {imm_i[11:0], 20'd0};
            FmtS: imm_field_o = {imm_i[11:5], 13'd0, imm_i[4:0], 7'd0};
            FmtB: imm_field_o = {imm_i[12], imm_i[10:5], 13'd0, imm_i[4:1], imm_i[11], 7'd0};
            FmtU: imm_field_o = {imm_i[31:12], 12'd0};
            FmtJ: imm_field_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'd0};
            default: err_o = 1'b1;
        endcase
`ifdef ENC_RANGE_CHECK_EN
        // A value fits in N signed bits when bits [31:N-1] are all copies of the sign bit.
        case (fmt_i)
            FmtI, FmtS: err_o = err_o | (imm_i[31:11] != {21{imm_i[11]}});
            FmtB:       err_o = err_o | (imm_i[31:12] != {20{imm_i[12]}}) | imm_i[0];
            FmtJ:       err_o = err_o | (imm_i[31:20] != {12{imm_i[20]}}) | imm_i[0];
            FmtU:       err_o = err_o | (imm_i[11:0] != 12'd0);
            default:    err_o = err_o;
        endcase
`endif
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage instruction encoder with valid/ready handshakes on both sides.
// S1 captures a field set; S2 holds the encoded word, which is presented with the address
// counter value. The counter steps by 4 per delivered word and can be reloaded (word
// aligned) from base_addr; a reload wins over a simultaneous delivery.
// Optional feature: define ENC_RANGE_CHECK_EN to flag out-of-range immediates.
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   in_valid / in_ready        field-set handshake
//   fmt, opcode, func3, func7  format code and opcode/function fields
//   rd, rs1, rs2, imm          register indices and immediate
//   base_load, base_addr       address counter reload
//   out_valid / out_ready      encoded-word handshake
//   out_instr, out_addr        encoded word and its address
//   out_err                    field error (word is then a NOP)
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [6:0]  func7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    input  logic        base_load,
    input  logic [31:0] base_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err
);

    s1_fields_t  s1_q, s1_d;
    logic        s1_valid_q, s1_valid_d;
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic        s1_adv;
    logic [31:0] imm_field;
    logic [31:0] reg_field;
    logic        imm_err;
    logic        unused_base_lsbs;

    // Counter reloads are always word aligned.
    assign unused_base_lsbs = ^base_addr[1:0];

    instr_imm_pack u_imm_pack (
        .fmt_i       (s1_q.fmt),
        .imm_i       (s1_q.imm),
        .imm_field_o (imm_field),
        .err_o       (imm_err)
    );

    // Register and opcode fields of the captured set, per format.
    always_comb begin
        reg_field = '0;
        case (s1_q.fmt)
            FmtR:       reg_field = {s1_q.func7, s1_q.rs2, s1_q.rs1, s1_q.func3, s1_q.rd,
                                     s1_q.opcode};
            FmtI:       reg_field = {12'd0, s1_q.rs1, s1_q.func3, s1_q.rd, s1_q.opcode};
            FmtS, FmtB: reg_field = {7'd0, s1_q.rs2, s1_q.rs1, s1_q.func3, 5'd0, s1_q.opcode};
            FmtU, FmtJ: reg_field = {20'd0, s1_q.rd, s1_q.opcode};
            default:    reg_field = '0;
        endcase
    end

    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        instr_d    = instr_q;
        err_d      = err_q;
        addr_d     = addr_q;

        s1_adv   = !s2_valid_q || out_ready;
        in_ready = !s1_valid_q || s1_adv;

        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_valid && in_ready) begin
            s1_d = '{fmt: fmt, opcode: opcode, func3: func3, func7: func7,
                     rd: rd, rs1: rs1, rs2: rs2, imm: imm};
        end

        // S2 only reloads when it advances with a valid S1, so a stalled word stays put.
        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                instr_d = imm_err ? NopInstr : (reg_field | imm_field);
                err_d   = imm_err;
            end
        end

        if (base_load) begin
            addr_d = {base_addr[31:2], 2'b00};
        end else if (s2_valid_q && out_ready) begin
            addr_d = addr_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            instr_q    <= '0;
            err_q      <= 1'b0;
            addr_q     <= '0;
        end else begin
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            instr_q    <= instr_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_instr = instr_q;
    assign out_err   = err_q;
    assign out_addr  = addr_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words are queued on every accepted field
// set and compared, with the expected address, on every delivered word.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode, func7;
    logic [2:0]  func3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        base_load;
    logic [31:0] base_addr;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_instr, out_addr;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .func3     (func3),
        .func7     (func7),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .base_load (base_load),
        .base_addr (base_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .out_err   (out_err)
    );

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
        int          cyc;
    } got_t;

    exp_t        exp_q[$];
    got_t        got_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] addr_model = '0;
    bit          accepted;

    // Reference encoding built from the instruction-set field layouts.
    function automatic exp_t model(input logic [2:0] f, input logic [6:0] op,
                                   input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [4:0] d, input logic [4:0] r1,
                                   input logic [4:0] r2, input logic [31:0] im);
        exp_t        e;
        logic [31:0] w;
        logic        bad;
        int          s;
        s   = $signed(im);
        bad = (f > 3'd5);
        case (f)
            3'd0:    w = {f7, r2, r1, f3, d, op};
            3'd1:    w = {im[11:0], r1, f3, d, op};
            3'd2:    w = {im[11:5], r2, r1, f3, im[4:0], op};
            3'd3:    w = {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], op};
            3'd4:    w = {im[31:12], d, op};
            3'd5:    w = {im[20], im[10:1], im[11], im[19:12], d, op};
            default: w = 32'h00000013;
        endcase
`ifdef ENC_RANGE_CHECK_EN
        if (f == 3'd1 || f == 3'd2) bad = bad || s < -2048 || s > 2047;
        if (f == 3'd3) bad = bad || s < -4096 || s > 4095 || im[0];
        if (f == 3'd5) bad = bad || s < -1048576 || s > 1048575 || im[0];
        if (f == 3'd4) bad = bad || im[11:0] != 12'd0;
`else
        if (s == 0) bad = bad;
`endif
        e.instr = bad ? 32'h00000013 : w;
        e.err   = bad;
        return e;
    endfunction

    // One clock: observe handshakes at the falling edge, then step to just after the rise.
    task automatic tick();
        got_t g;
        exp_t e;
        @(negedge clk);
        accepted = 1'b0;
        if (reset_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(fmt, opcode, func3, func7, rd, rs1, rs2, imm));
                accepted = 1'b1;
            end
            if (out_valid && out_ready) begin
                g.instr = out_instr;
                g.addr  = out_addr;
                g.err   = out_err;
                g.cyc   = cyc;
                got_q.push_back(g);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got instr %08h, required no output", out_instr);
                end else begin
                    e = exp_q.pop_front();
                    checks += 2;
                    if (out_instr !== e.instr) begin
                        errors++;
                        $display("FAIL sb_instr: got %08h, required %08h", out_instr, e.instr);
                    end
                    if (out_err !== e.err) begin
                        errors++;
                        $display("FAIL sb_err: got %0b, required %0b", out_err, e.err);
                    end
                    if (out_addr !== addr_model) begin
                        errors++;
                        $display("FAIL sb_addr: got %08h, required %08h", out_addr, addr_model);
                    end
                end
                addr_model = addr_model + 32'd4;
            end
            if (base_load) addr_model = {base_addr[31:2], 2'b00};
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] d, input logic [4:0] r1,
                              input logic [4:0] r2, input logic [31:0] im);
        fmt = f; opcode = op; func3 = f3; func7 = f7; rd = d; rs1 = r1; rs2 = r2; imm = im;
    endtask

    // Offer a field set and wait (bounded) for it to be accepted; in_valid is left high.
    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] d, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [31:0] im);
        int n;
        set_fields(f, op, f3, f7, d, r1, r2, im);
        in_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!accepted && n < 50);
        checks++;
        if (!accepted) begin
            errors++;
            $display("FAIL send_timeout: accepted %0b, required 1", accepted);
        end
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: pending %0d, required 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        base_load = 1'b0;
        reset_n   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_q.delete();
        got_q.delete();
        addr_model = '0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        base_load = 1'b0;
        base_addr = '0;
        set_fields(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        #2 reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %0b, required 0", out_valid);
        end
        if (out_instr !== 32'd0) begin
            errors++; $display("FAIL reset_out_instr: got %08h, required 00000000", out_instr);
        end
        if (out_err !== 1'b0) begin
            errors++; $display("FAIL reset_out_err: got %0b, required 0", out_err);
        end
        if (out_addr !== 32'd0) begin
            errors++; $display("FAIL reset_out_addr: got %08h, required 00000000", out_addr);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        do_reset();
        send(FmtI, OpcOpImm, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        drain();
        checks += 3;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL basic_count: got %0d, required 1", got_q.size());
        end
        if (got_q[0].instr !== 32'h00500093 || got_q[0].err !== 1'b0) begin
            errors++;
            $display("FAIL basic_instr: got %08h/%0b, required 00500093/0",
                     got_q[0].instr, got_q[0].err);
        end
        if (got_q[0].addr !== 32'd0) begin
            errors++; $display("FAIL basic_addr: got %08h, required 00000000", got_q[0].addr);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send(FmtR, OpcOp, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        send(FmtS, OpcStore, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
        drain();
        checks += 3;
        if (got_q[0].instr !== 32'h002081B3 || got_q[0].addr !== 32'd0) begin
            errors++;
            $display("FAIL b2b_first: got %08h@%08h, required 002081b3@00000000",
                     got_q[0].instr, got_q[0].addr);
        end
        if (got_q[1].instr !== 32'h0020A423 || got_q[1].addr !== 32'd4) begin
            errors++;
            $display("FAIL b2b_second: got %08h@%08h, required 0020a423@00000004",
                     got_q[1].instr, got_q[1].addr);
        end
        if (got_q.size() != 2 || got_q[1].cyc != got_q[0].cyc + 1) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d words gap %0d, required 2 words gap 1",
                     got_q.size(), got_q[1].cyc - got_q[0].cyc);
        end
    endtask

    task automatic test_formats();
        logic [31:0] ew [6];
        logic        ee [6];
        ew[0] = 32'hFE000EE3; ee[0] = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
        ew[1] = 32'h00000013; ee[1] = 1'b1;
`else
        ew[1] = 32'h00000163; ee[1] = 1'b0;
`endif
        ew[2] = 32'h123452B7; ee[2] = 1'b0;
        ew[3] = 32'h008000EF; ee[3] = 1'b0;
        ew[4] = 32'h00000013; ee[4] = 1'b1;
        ew[5] = 32'h00000013; ee[5] = 1'b1;
        do_reset();
        send(FmtB, OpcBranch, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC);
        send(FmtB, OpcBranch, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3);
        send(FmtU, OpcLui, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
        send(FmtJ, OpcJal, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);
        send(3'd6, OpcOp, 3'd1, 7'd1, 5'd3, 5'd4, 5'd5, 32'd7);
        send(3'd7, OpcOp, 3'd1, 7'd1, 5'd3, 5'd4, 5'd5, 32'd7);
        drain();
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (got_q[k].instr !== ew[k] || got_q[k].err !== ee[k]) begin
                errors++;
                $display("FAIL fmt_word%0d: got %08h/%0b, required %08h/%0b",
                         k, got_q[k].instr, got_q[k].err, ew[k], ee[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        int          idx;
        int          n;
        bit          held;
        logic [31:0] hold_w;
        exp_t        e;
        do_reset();
        out_ready = 1'b0;
        idx  = 0;
        held = 1'b0;
        hold_w = '0;
        for (int c = 0; c < 5; c++) begin
            set_fields(FmtI, OpcOpImm, 3'd0, 7'd0, 5'(idx + 1), 5'(idx), 5'd0, 32'(idx * 16 + 1));
            in_valid = 1'b1;
            tick();
            if (accepted) idx++;
            if (out_valid) begin
                if (!held) begin
                    held   = 1'b1;
                    hold_w = out_instr;
                end else begin
                    checks++;
                    if (out_instr !== hold_w) begin
                        errors++;
                        $display("FAIL bp_stable: got %08h, required %08h", out_instr, hold_w);
                    end
                end
            end
        end
        e = model(FmtI, OpcOpImm, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        checks += 4;
        if (idx != 2) begin
            errors++; $display("FAIL bp_buffered: got %0d, required 2", idx);
        end
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_in_ready: got %0b, required 0", in_ready);
        end
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_out_valid: got %0b, required 1", out_valid);
        end
        if (out_instr !== e.instr) begin
            errors++; $display("FAIL bp_head: got %08h, required %08h", out_instr, e.instr);
        end
        out_ready = 1'b1;
        n = 0;
        while (idx < 4 && n < 50) begin
            set_fields(FmtI, OpcOpImm, 3'd0, 7'd0, 5'(idx + 1), 5'(idx), 5'd0, 32'(idx * 16 + 1));
            in_valid = 1'b1;
            tick();
            if (accepted) idx++;
            n++;
        end
        drain();
        for (int k = 0; k < 4; k++) begin
            e = model(FmtI, OpcOpImm, 3'd0, 7'd0, 5'(k + 1), 5'(k), 5'd0, 32'(k * 16 + 1));
            checks++;
            if (got_q[k].instr !== e.instr || got_q[k].addr !== 32'(k * 4)) begin
                errors++;
                $display("FAIL bp_order%0d: got %08h@%08h, required %08h@%08h",
                         k, got_q[k].instr, got_q[k].addr, e.instr, 32'(k * 4));
            end
        end
    endtask

    task automatic test_base_load();
        int n;
        do_reset();
        out_ready = 1'b0;
        send(FmtI, OpcOpImm, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        send(FmtI, OpcOpImm, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        base_load = 1'b1;
        base_addr = 32'h00001003;
        out_ready = 1'b1;
        tick();
        base_load = 1'b0;
        send(FmtI, OpcOpImm, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd3);
        drain();
        checks += 3;
        if (got_q[0].addr !== 32'd0) begin
            errors++; $display("FAIL load_cur_addr: got %08h, required 00000000", got_q[0].addr);
        end
        if (got_q[1].addr !== 32'h00001000) begin
            errors++;
            $display("FAIL load_next_addr: got %08h, required 00001000", got_q[1].addr);
        end
        if (got_q[2].addr !== 32'h00001004) begin
            errors++;
            $display("FAIL load_after_addr: got %08h, required 00001004", got_q[2].addr);
        end
    endtask

    task automatic test_reset_flush();
        do_reset();
        base_load = 1'b1;
        base_addr = 32'h00000040;
        tick();
        base_load = 1'b0;
        out_ready = 1'b0;
        send(FmtI, OpcOpImm, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        send(FmtI, OpcOpImm, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2);
        in_valid = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_full: got ready %0b valid %0b, required 0 1", in_ready, out_valid);
        end
        reset_n = 1'b0;
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_valid: got %0b, required 0", out_valid);
        end
        if (out_addr !== 32'd0) begin
            errors++; $display("FAIL flush_addr: got %08h, required 00000000", out_addr);
        end
        exp_q.delete();
        got_q.delete();
        addr_model = '0;
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        repeat (5) tick();
        checks++;
        if (got_q.size() != 0) begin
            errors++; $display("FAIL flush_stale: got %0d words, required 0", got_q.size());
        end
        send(FmtI, OpcOpImm, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 32'd4);
        drain();
        checks++;
        if (got_q[0].addr !== 32'd0) begin
            errors++; $display("FAIL flush_new_addr: got %08h, required 00000000", got_q[0].addr);
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            r = ($urandom % 2 == 0) ? $urandom : 32'($urandom_range(0, 8191)) - 32'd4096;
            set_fields(3'($urandom_range(0, 7)), 7'($urandom), 3'($urandom), 7'($urandom),
                       5'($urandom), 5'($urandom), 5'($urandom), r);
            in_valid  = ($urandom % 2) == 0;
            out_ready = ($urandom % 4) != 0;
            base_load = ($urandom % 32) == 0;
            base_addr = $urandom;
            tick();
        end
        base_load = 1'b0;
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_formats();
        test_backpressure();
        test_base_load();
        test_reset_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
